// File: rtl/aes_round_ctrl_if.sv
// Handshake/status bundle between the AES round controller and its requester.
interface aes_round_ctrl_if #(
  parameter int unsigned ROUND_W = 4
) ();
  logic               start_i;
  logic [1:0]         key_len_i;
  logic               decrypt_i;
  logic               stall_i;
  logic               load_o;
  logic               busy_o;
  logic               init_o;
  logic               mix_en_o;
  logic               last_o;
  logic [ROUND_W-1:0] round_o;
  logic [ROUND_W-1:0] rk_idx_o;
  logic               decrypt_o;
  logic               done_o;
  logic               err_o;

  modport slave (
    input  start_i, key_len_i, decrypt_i, stall_i,
    output load_o, busy_o, init_o, mix_en_o, last_o,
           round_o, rk_idx_o, decrypt_o, done_o, err_o
  );

  modport master (
    output start_i, key_len_i, decrypt_i, stall_i,
    input  load_o, busy_o, init_o, mix_en_o, last_o,
           round_o, rk_idx_o, decrypt_o, done_o, err_o
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: LOAD -> INIT -> ROUND x Nr -> DONE with stall support.
// Every output is a register loaded from the next-state decode.
module aes_round_ctrl #(
  parameter int unsigned ROUND_W   = 4,
  parameter int unsigned KEY_MODES = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  aes_round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_INIT  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  function automatic logic [ROUND_W-1:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      2'b00:   nr_of = ROUND_W'(10);
      2'b01:   nr_of = ROUND_W'(12);
      default: nr_of = ROUND_W'(14);
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [ROUND_W-1:0] nr_q, nr_d;
  logic [ROUND_W-1:0] rk_q, rk_d;
  logic               dec_q, dec_d;
  logic               err_q, err_d;
  logic               load_q, load_d;
  logic               busy_q, busy_d;
  logic               init_q, init_d;
  logic               mix_q, mix_d;
  logic               last_q, last_d;
  logic               done_q, done_d;
  logic               key_ok_s;

  assign key_ok_s = (bus.key_len_i != 2'b11) && ({30'd0, bus.key_len_i} < KEY_MODES);

  // Next-state, round counter and output decode of the next state.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    nr_d    = nr_q;
    dec_d   = dec_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        round_d = '0;
        if (bus.start_i) begin
          if (key_ok_s) begin
            state_d = S_LOAD;
            nr_d    = nr_of(bus.key_len_i);
            dec_d   = bus.decrypt_i;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (!bus.stall_i) begin
          state_d = S_INIT;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_INIT: begin
        if (!bus.stall_i) begin
          state_d = S_ROUND;
          round_d = ROUND_W'(1);
        end else begin
          state_d = S_INIT;
        end
      end
      S_ROUND: begin
        if (bus.stall_i) begin
          state_d = S_ROUND;
        end else if (round_q < nr_q) begin
          round_d = round_q + ROUND_W'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        round_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        round_d = '0;
      end
    endcase

    load_d = (state_d == S_LOAD);
    init_d = (state_d == S_INIT);
    busy_d = (state_d == S_LOAD) || (state_d == S_INIT) || (state_d == S_ROUND);
    mix_d  = (state_d == S_ROUND) && (round_d < nr_d);
    last_d = (state_d == S_ROUND) && (round_d == nr_d);
    done_d = (state_d == S_DONE);
    if ((state_d == S_INIT) || (state_d == S_ROUND)) begin
      rk_d = dec_d ? (nr_d - round_d) : round_d;
    end else begin
      rk_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      round_q <= '0;
      nr_q    <= '0;
      rk_q    <= '0;
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      init_q  <= 1'b0;
      mix_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      nr_q    <= nr_d;
      rk_q    <= rk_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      init_q  <= init_d;
      mix_q   <= mix_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign bus.load_o    = load_q;
  assign bus.busy_o    = busy_q;
  assign bus.init_o    = init_q;
  assign bus.mix_en_o  = mix_q;
  assign bus.last_o    = last_q;
  assign bus.round_o   = round_q;
  assign bus.rk_idx_o  = rk_q;
  assign bus.decrypt_o = dec_q;
  assign bus.done_o    = done_q;
  assign bus.err_o     = err_q;

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter ROUND_W, default 4: width of round_o and rk_idx_o; SHALL be >= 4.
REQ-002 Parameter KEY_MODES, default 3: number of supported key lengths (1 = AES-128 only; 2 = AES-128/192; 3 = AES-128/192/256).
REQ-003 clk_i  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 start_i  in  1  operation request; sampled only in IDLE.
REQ-006 key_len_i  in  2  key length: 00 = 128 (Nr=10), 01 = 192 (Nr=12), 10 = 256 (Nr=14), 11 = reserved.
REQ-007 decrypt_i  in  1  operation mode: 0 = encrypt, 1 = decrypt.
REQ-008 stall_i  in  1  freezes progress while high in LOAD, INIT or ROUND.
REQ-009 load_o  out  1  load plaintext and key into the datapath.
REQ-010 busy_o  out  1  operation in progress.
REQ-011 init_o  out  1  initial AddRoundKey cycle (round 0).
REQ-012 mix_en_o  out  1  enable MixColumns/InvMixColumns for the current round.
REQ-013 last_o  out  1  final round (no MixColumns).
REQ-014 round_o  out  ROUND_W  current round number.
REQ-015 rk_idx_o  out  ROUND_W  round-key index for the key schedule.
REQ-016 decrypt_o  out  1  latched operation mode.
REQ-017 done_o  out  1  one-cycle completion pulse.
REQ-018 err_o  out  1  one-cycle pulse: start rejected.

Function
REQ-019 The FSM SHALL have exactly five states: IDLE, LOAD, INIT, ROUND, DONE.
REQ-020 All outputs except err_o SHALL be Moore decodes of registered state, with no combinational path from any input.
REQ-021 IDLE with start_i=1 and a supported key_len_i SHALL go to LOAD, latching Nr from key_len_i and decrypt_i into decrypt_o.
REQ-022 A key length is supported when key_len_i != 11 and key_len_i < KEY_MODES.
REQ-023 IDLE with start_i=1 and an unsupported key_len_i SHALL stay in IDLE and assert err_o on the next cycle only.
REQ-024 LOAD -> INIT -> ROUND SHALL each take one cycle, with round_o = 1 on ROUND entry.
REQ-025 In ROUND: when round_o < Nr, round_o SHALL increment and the FSM stays in ROUND; when round_o == Nr, the FSM goes to DONE.
REQ-026 DONE SHALL last one cycle and then return to IDLE.
REQ-027 When stall_i=1 in LOAD, INIT or ROUND, state, round_o and all outputs SHALL hold; stall_i has no effect in IDLE or DONE.
REQ-028 start_i, key_len_i and decrypt_i SHALL be ignored outside IDLE; latched Nr and mode are fixed until the next start.
REQ-029 Outputs per state:
  - load_o = 1 only in LOAD; init_o = 1 only in INIT.
  - busy_o = 1 in LOAD, INIT and ROUND.
  - mix_en_o = 1 in ROUND with round_o < Nr.
  - last_o = 1 in ROUND with round_o == Nr.
  - done_o = 1 only in DONE.
REQ-030 round_o SHALL be 0 in IDLE, LOAD and INIT, and SHALL hold Nr in DONE.
REQ-031 rk_idx_o SHALL equal round_o when decrypt_o = 0 and Nr - round_o when decrypt_o = 1, in INIT and ROUND; it SHALL be 0 elsewhere.
REQ-032 Latency without stall SHALL be: start accepted in cycle c0, done_o high in cycle c0+Nr+3 (13 / 15 / 17 cycles); each stall cycle adds exactly one cycle.
REQ-033 An illegal state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-034 rst_ni low SHALL immediately force IDLE, round_o = 0, rk_idx_o = 0, decrypt_o = 0, and every 1-bit output = 0, including mid-operation.
REQ-035 After rst_ni deasserts, the first start_i SHALL be accepted on the first rising edge.

Verification
REQ-036 key_len=00, decrypt=0, start pulse -> load_o in c1; init_o in c2; round_o 1..10 in c3..c12; mix_en_o in c3..c11; last_o in c12; done_o in c13; rk_idx_o == round_o.
REQ-037 key_len=10, decrypt=1 -> last_o with round_o=14; rk_idx_o goes 14,13,...,0 from INIT to the last round; done_o in c17.
REQ-038 KEY_MODES=1, key_len=01 -> err_o high in c1 only; busy_o stays 0; a following start with key_len=00 is accepted.
REQ-039 stall_i high for 3 cycles at round 5 -> round_o holds at 5 for 4 cycles total; done_o delayed by 3 cycles.
REQ-040 rst_ni pulsed low at round 7 -> all outputs 0 asynchronously; a new start after release completes normally.
REQ-041 start_i held high through DONE -> a new operation begins from IDLE only, with no start accepted while busy_o = 1.
